muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM state type for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative mult/multu/div/divu: WIDTH cycles per op, 1 cycle for divide-by-zero.
// Define MULDIV_EARLY_OUT_EN to let multiplies stop once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             annul,
  output logic             stallreq,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;   // mul: running product; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mc_q;    // mul: multiplicand shifted left each iteration
  logic [WIDTH-1:0]   m_q;     // mul: multiplier shifted right; div: divisor
  logic               neg_q;
  logic               neg_rem_q;
  logic               dbz_q;

  logic             accept;
  logic             is_signed;
  logic             is_div;
  logic             src2_zero;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             cnt_last;
  logic             mul_last;

  assign accept    = (state_q == IDLE) && start && !annul;
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign src2_zero = (src2 == '0);
  assign mag1      = (is_signed && src1[WIDTH-1]) ? -src1 : src1;
  assign mag2      = (is_signed && src2[WIDTH-1]) ? -src2 : src2;
  assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = cnt_last || (m_q[WIDTH-1:1] == '0);
`else
  assign mul_last = cnt_last;
`endif

  // One shift-add step.
  logic [2*WIDTH-1:0] mul_nxt;
  assign mul_nxt = acc_q + (m_q[0] ? mc_q : '0);

  // One restoring-division step; bit WIDTH of diff is the borrow.
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   new_rem;
  logic [2*WIDTH-1:0] div_nxt;
  assign rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, m_q};
  assign fits      = !diff[WIDTH];
  assign new_rem   = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign div_nxt   = {new_rem, acc_q[WIDTH-2:0], fits};

  // Sign fix-up on the value the final iteration produces.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  assign quo = div_nxt[WIDTH-1:0];
  assign rem = div_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    prod_s = neg_q ? -mul_nxt : mul_nxt;
    res_hi = '0;
    res_lo = '0;
    if (state_q == MUL) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else begin
      res_hi = neg_rem_q ? -rem : rem;
      res_lo = neg_q ? -quo : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_div && src2_zero) state_d = DONE;
          else if (is_div)         state_d = DIV;
          else                     state_d = MUL;
        end
      end
      MUL: begin
        if (annul)         state_d = IDLE;
        else if (mul_last) state_d = DONE;
      end
      DIV: begin
        if (annul)         state_d = IDLE;
        else if (cnt_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mc_q      <= '0;
      m_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q     <= '0;
            neg_q     <= is_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
            neg_rem_q <= is_signed && src1[WIDTH-1];
            dbz_q     <= 1'b0;
            m_q       <= mag2;
            if (is_div) begin
              acc_q <= {{WIDTH{1'b0}}, mag1};
              if (src2_zero) begin
                hi    <= src1;
                lo    <= '1;
                dbz_q <= 1'b1;
              end
            end else begin
              acc_q <= '0;
              mc_q  <= {{WIDTH{1'b0}}, mag1};
            end
          end
        end
        MUL: begin
          acc_q <= mul_nxt;
          mc_q  <= {mc_q[2*WIDTH-2:0], 1'b0};
          m_q   <= {1'b0, m_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (mul_last && !annul) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        DIV: begin
          acc_q <= div_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_last && !annul) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign stallreq    = accept || (state_q == MUL) || (state_q == DIV);
  assign done        = (state_q == DONE);
  assign div_by_zero = done && dbz_q;

endmodule
